// File: rtl/regfile_wb_if.sv
// Bundle between the issue/write-back side and the register-set scheduler.
// The master drives requests; the slave is the scheduler itself.
interface regfile_wb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    localparam int NR = 1 << AW;

    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   iss_rs1;
    logic [AW-1:0]   iss_rs2;
    logic            iss_use_rs1;
    logic            iss_use_rs2;
    logic            iss_ready;

    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    logic            rf_write;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NR-1:0]   pending;
    logic            sb_err;

    modport master (
        output iss_valid, iss_rd, iss_rs1, iss_rs2,
        output iss_use_rs1, iss_use_rs2,
        input  iss_ready,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        input  rf_write, rf_waddr, rf_wdata,
        input  pending, sb_err
    );

    modport slave (
        input  iss_valid, iss_rd, iss_rs1, iss_rs2,
        input  iss_use_rs1, iss_use_rs2,
        output iss_ready,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        output rf_write, rf_waddr, rf_wdata,
        output pending, sb_err
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Write-back arbiter (ALU vs LSU, round-robin on contention) and
// pending-write scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input logic         clk,
    input logic         rstn,
    regfile_wb_if.slave bus
);
    localparam int NR = 1 << AW;

    logic [NR-1:0]   pending_q, pending_d;
    logic            ptr_q, ptr_d;
    logic            sb_err_q, sb_err_d;
    logic            rf_write_q, rf_write_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    logic            alu_gnt, lsu_gnt;
    logic            xfer;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            iss_ok;
    logic            iss_fire;

    // Hazard check: any used source or a non-x0 destination still pending.
    always_comb begin
        iss_ok = 1'b1;
        if (bus.iss_use_rs1 && pending_q[bus.iss_rs1])
            iss_ok = 1'b0;
        if (bus.iss_use_rs2 && pending_q[bus.iss_rs2])
            iss_ok = 1'b0;
        if ((bus.iss_rd != '0) && pending_q[bus.iss_rd])
            iss_ok = 1'b0;
        iss_fire = bus.iss_valid && iss_ok;
    end

    // Round-robin grant; the pointer only matters when both request.
    always_comb begin
        alu_gnt = bus.alu_valid && (!bus.lsu_valid || !ptr_q);
        lsu_gnt = bus.lsu_valid && (!bus.alu_valid || ptr_q);
        xfer    = alu_gnt || lsu_gnt;
        wb_rd   = lsu_gnt ? bus.lsu_rd : bus.alu_rd;
        wb_data = lsu_gnt ? bus.lsu_data : bus.alu_data;
    end

    // Next state: write register, pointer, scoreboard and error flag.
    always_comb begin
        rf_write_d = xfer && (wb_rd != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (xfer) begin
            rf_waddr_d = wb_rd;
            rf_wdata_d = wb_data;
        end

        ptr_d = ptr_q;
        if (bus.alu_valid && bus.lsu_valid)
            ptr_d = !ptr_q;

        pending_d = pending_q;
        if (rf_write_q)
            pending_d[rf_waddr_q] = 1'b0;
        if (iss_fire && (bus.iss_rd != '0))
            pending_d[bus.iss_rd] = 1'b1;
        pending_d[0] = 1'b0;

        sb_err_d = sb_err_q;
        if (xfer && (wb_rd != '0) && !pending_q[wb_rd])
            sb_err_d = 1'b1;
    end

    // State registers, cleared asynchronously by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q  <= '0;
            ptr_q      <= 1'b0;
            sb_err_q   <= 1'b0;
            rf_write_q <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            sb_err_q   <= sb_err_d;
            rf_write_q <= rf_write_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign bus.iss_ready = iss_ok;
    assign bus.alu_ready = alu_gnt;
    assign bus.lsu_ready = lsu_gnt;
    assign bus.rf_write  = rf_write_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.pending   = pending_q;
    assign bus.sb_err    = sb_err_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for the write-back scheduler: reset, RAW/WAW stalls,
// contention, x0 writes, sb_err and back-to-back write-backs.
module tb_regfile_wb_scheduler;
    logic clk;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    regfile_wb_if #(.XLEN(32), .AW(5)) bus ();

    regfile_wb_scheduler #(.XLEN(32), .AW(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1);
        bus.iss_valid   = v;
        bus.iss_rd      = rd;
        bus.iss_rs1     = rs1;
        bus.iss_use_rs1 = u1;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd,
                       input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd,
                       input logic [31:0] d);
        bus.lsu_valid = v;
        bus.lsu_rd    = rd;
        bus.lsu_data  = d;
    endtask

    initial begin
        rstn = 1'b0;
        issue(0, 0, 0, 0);
        bus.iss_rs2     = '0;
        bus.iss_use_rs2 = 1'b0;
        alu(0, 0, 0);
        lsu(0, 0, 0);
        #2;
        check("rst_rf_write", 32'(bus.rf_write), 0);
        check("rst_waddr", 32'(bus.rf_waddr), 0);
        check("rst_wdata", bus.rf_wdata, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_sb_err", 32'(bus.sb_err), 0);
        check("rst_iss_ready", 32'(bus.iss_ready), 1);
        #10 rstn = 1'b1;

        // RAW stall
        issue(1, 5, 0, 0);
        tick();
        check("raw_set", bus.pending, 32'h20);
        issue(1, 6, 5, 1);
        #1 check("raw_stall0", 32'(bus.iss_ready), 0);
        tick();
        check("raw_stall1", 32'(bus.iss_ready), 0);
        alu(1, 5, 32'hDEADBEEF);
        #1 check("raw_alu_gnt", 32'(bus.alu_ready), 1);
        tick();
        alu(0, 0, 0);
        check("raw_g1_write", 32'(bus.rf_write), 1);
        check("raw_g1_waddr", 32'(bus.rf_waddr), 5);
        check("raw_g1_wdata", bus.rf_wdata, 32'hDEADBEEF);
        #1 check("raw_g1_stall", 32'(bus.iss_ready), 0);
        tick();
        check("raw_g2_ready", 32'(bus.iss_ready), 1);
        tick();
        issue(0, 0, 0, 0);
        check("raw_rd6_set", bus.pending, 32'h40);

        // Contention: mark x10..x15 pending first
        for (int r = 10; r <= 15; r++) begin
            issue(1, 5'(r), 0, 0);
            tick();
        end
        issue(0, 0, 0, 0);
        check("cont_pend", bus.pending, 32'h0000_FC40);
        alu(1, 10, 32'hA0);
        lsu(1, 11, 32'hB1);
        #1 check("cont1_alu", 32'(bus.alu_ready), 1);
        check("cont1_lsu", 32'(bus.lsu_ready), 0);
        tick();
        check("cont1_waddr", 32'(bus.rf_waddr), 10);
        alu(1, 12, 32'hA2);
        #1 check("cont2_lsu", 32'(bus.lsu_ready), 1);
        check("cont2_alu", 32'(bus.alu_ready), 0);
        tick();
        check("cont2_waddr", 32'(bus.rf_waddr), 11);
        lsu(1, 13, 32'hB3);
        #1 check("cont3_alu", 32'(bus.alu_ready), 1);
        tick();
        check("cont3_waddr", 32'(bus.rf_waddr), 12);
        alu(1, 14, 32'hA4);
        #1 check("cont4_lsu", 32'(bus.lsu_ready), 1);
        tick();
        check("cont4_waddr", 32'(bus.rf_waddr), 13);
        check("cont4_wdata", bus.rf_wdata, 32'hB3);
        lsu(1, 15, 32'hB5);
        #1 check("cont5_ptr0_alu", 32'(bus.alu_ready), 1);
        tick();
        alu(0, 0, 0);
        #1 check("cont6_lsu_alone", 32'(bus.lsu_ready), 1);
        tick();
        lsu(0, 0, 0);
        check("cont6_waddr", 32'(bus.rf_waddr), 15);
        tick();
        check("cont_idle_write", 32'(bus.rf_write), 0);
        check("cont_pend_done", bus.pending, 32'h40);
        check("cont_sb_err", 32'(bus.sb_err), 0);

        // Write-back to x0
        lsu(1, 0, 32'h1234);
        #1 check("x0_lsu_ready", 32'(bus.lsu_ready), 1);
        tick();
        lsu(0, 0, 0);
        check("x0_rf_write", 32'(bus.rf_write), 0);
        check("x0_waddr", 32'(bus.rf_waddr), 0);
        check("x0_wdata", bus.rf_wdata, 32'h1234);
        tick();
        check("x0_pending", bus.pending, 32'h40);
        check("x0_sb_err", 32'(bus.sb_err), 0);

        // WAW on x7
        issue(1, 7, 0, 0);
        tick();
        check("waw_set", bus.pending, 32'hC0);
        #1 check("waw_stall0", 32'(bus.iss_ready), 0);
        alu(1, 7, 32'h77);
        #1 check("waw_alu_gnt", 32'(bus.alu_ready), 1);
        tick();
        alu(0, 0, 0);
        check("waw_g1_stall", 32'(bus.iss_ready), 0);
        tick();
        check("waw_g2_ready", 32'(bus.iss_ready), 1);
        tick();
        issue(0, 0, 0, 0);
        check("waw_reset_bit", bus.pending, 32'hC0);

        // Write-back with no pending bit
        alu(1, 9, 32'h99);
        tick();
        alu(0, 0, 0);
        check("sberr_set", 32'(bus.sb_err), 1);
        tick();
        tick();
        check("sberr_hold", 32'(bus.sb_err), 1);
        check("sberr_pend", bus.pending, 32'hC0);

        // Back-to-back write-backs to x1..x3
        for (int r = 1; r <= 3; r++) begin
            issue(1, 5'(r), 0, 0);
            tick();
        end
        issue(0, 0, 0, 0);
        check("b2b_pend", bus.pending, 32'hCE);
        alu(1, 1, 32'h11);
        tick();
        check("b2b1_write", 32'(bus.rf_write), 1);
        check("b2b1_waddr", 32'(bus.rf_waddr), 1);
        alu(1, 2, 32'h22);
        tick();
        check("b2b2_write", 32'(bus.rf_write), 1);
        check("b2b2_waddr", 32'(bus.rf_waddr), 2);
        check("b2b2_pend", bus.pending, 32'hCC);
        alu(1, 3, 32'h33);
        tick();
        alu(0, 0, 0);
        check("b2b3_write", 32'(bus.rf_write), 1);
        check("b2b3_waddr", 32'(bus.rf_waddr), 3);
        check("b2b3_pend", bus.pending, 32'hC8);
        tick();
        check("b2b_end_write", 32'(bus.rf_write), 0);
        check("b2b_end_pend", bus.pending, 32'hC0);

        // Asynchronous reset mid-stream
        issue(1, 2, 0, 0);
        tick();
        issue(1, 5, 0, 0);
        tick();
        issue(0, 0, 0, 0);
        check("mid_pend", bus.pending, 32'hE4);
        alu(1, 6, 32'h66);
        tick();
        alu(0, 0, 0);
        check("mid_write", 32'(bus.rf_write), 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_write", 32'(bus.rf_write), 0);
        check("mid_rst_waddr", 32'(bus.rf_waddr), 0);
        check("mid_rst_wdata", bus.rf_wdata, 0);
        check("mid_rst_pend", bus.pending, 0);
        check("mid_rst_sberr", 32'(bus.sb_err), 0);
        check("mid_rst_iss", 32'(bus.iss_ready), 1);
        #1 rstn = 1'b1;
        tick();
        check("post_rst_write", 32'(bus.rf_write), 0);
        check("post_rst_pend", bus.pending, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
